// File: rtl/stack_xfer_engine.sv
// Multi-register PUSH/POP sequencer: one stack word per cycle against data memory,
// with an optional link/PC slot and optional stack-pointer write-back.
module stack_xfer_engine #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int RIW  = 3,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            op_pop,
  input  logic [NREG:0]   reg_mask,
  input  logic            wb,
  input  logic [AW-1:0]   sp_in,
  input  logic [AW-1:0]   lr_in,
  output logic [RIW-1:0]  rf_raddr,
  input  logic [DW-1:0]   rf_rdata,
  output logic [RIW-1:0]  rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            rf_wr,
  output logic            pc_wr,
  output logic [AW-1:0]   pc_data,
  output logic [AW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic [DW-1:0]   dmem_rdata,
  output logic            dmem_wr,
  output logic            sp_wr,
  output logic [AW-1:0]   sp_out,
  output logic            busy,
  output logic            done
);

  localparam int KW = $clog2(NREG + 2);
  localparam int SW = RIW + 1;
  localparam logic [NREG:0] MASK_ONE = {{NREG{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, PUSH, POP, POP_TAIL, FIN} state_t;

  function automatic logic [KW-1:0] popcnt(input logic [NREG:0] m);
    logic [KW-1:0] c;
    c = '0;
    for (int i = 0; i <= NREG; i++) c = c + KW'(m[i]);
    return c;
  endfunction

  function automatic logic [SW-1:0] lowest(input logic [NREG:0] m);
    logic [SW-1:0] s;
    s = '0;
    for (int i = NREG; i >= 0; i--) if (m[i]) s = SW'(i);
    return s;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [NREG:0]   r_mask;
  logic            r_wb;
  logic [AW-1:0]   r_lr, r_addr, r_spo;
  logic            r_pend_vld;
  logic [SW-1:0]   r_pend_slot;

  logic [KW-1:0]   w_k;
  logic [AW-1:0]   w_kstep;
  logic [SW-1:0]   w_slot;
  logic [NREG:0]   w_mask_nxt;
  logic            w_last;

  assign w_k        = popcnt(reg_mask);
  assign w_kstep    = AW'(w_k) * AW'(STEP);
  assign w_slot     = lowest(r_mask);
  assign w_mask_nxt = r_mask & (r_mask - MASK_ONE);
  assign w_last     = (w_mask_nxt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    sp_wr       = 1'b0;
    sp_out      = r_spo;
    dmem_wr     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    rf_raddr    = '0;
    rf_wr       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    pc_wr       = 1'b0;
    pc_data     = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_k == '0)   w_state_nxt = FIN;
          else if (op_pop) w_state_nxt = POP;
          else             w_state_nxt = PUSH;
        end
      end
      PUSH: begin
        dmem_wr   = 1'b1;
        dmem_addr = r_addr;
        rf_raddr  = w_slot[RIW-1:0];
        // The link slot stores the latched LR rather than an RF read.
        if (w_slot == SW'(NREG)) dmem_wdata = {{(DW-AW){1'b0}}, r_lr};
        else                     dmem_wdata = rf_rdata;
        if (w_last) w_state_nxt = FIN;
      end
      POP: begin
        dmem_addr = r_addr;
        if (w_last) w_state_nxt = POP_TAIL;
      end
      POP_TAIL: w_state_nxt = FIN;
      FIN: begin
        done        = 1'b1;
        sp_wr       = r_wb;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Read data returns one cycle after its issue; retire it to RF or PC.
    if (r_pend_vld) begin
      if (r_pend_slot == SW'(NREG)) begin
        pc_wr   = 1'b1;
        pc_data = dmem_rdata[AW-1:0];
      end else begin
        rf_wr    = 1'b1;
        rf_waddr = r_pend_slot[RIW-1:0];
        rf_wdata = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mask      <= '0;
      r_wb        <= 1'b0;
      r_lr        <= '0;
      r_addr      <= '0;
      r_spo       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_slot <= '0;
    end else begin
      r_pend_vld <= (r_state == POP);
      if (r_state == POP) r_pend_slot <= w_slot;
      if (r_state == IDLE && start) begin
        r_mask <= reg_mask;
        r_wb   <= wb && (w_k != '0);
        r_lr   <= lr_in;
        r_addr <= op_pop ? sp_in : sp_in - w_kstep;
        r_spo  <= op_pop ? sp_in + w_kstep : sp_in - w_kstep;
      end else if (r_state == PUSH || r_state == POP) begin
        r_mask <= w_mask_nxt;
        r_addr <= r_addr + AW'(STEP);
      end
    end
  end

endmodule

// File: tb/tb_stack_xfer_engine.sv
// Scoreboard bench for stack_xfer_engine: expected memory/RF/PC/done events are
// queued when an operation is launched and matched as the engine emits them.
module tb_stack_xfer_engine;

  logic        clk = 1'b0;
  logic        resetn, start, op_pop, wb;
  logic [8:0]  reg_mask;
  logic [15:0] sp_in, lr_in;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata, dmem_wdata, dmem_rdata;
  logic        rf_wr, pc_wr, dmem_wr, sp_wr, busy, done;
  logic [15:0] pc_data, dmem_addr, sp_out;

  stack_xfer_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .op_pop(op_pop),
    .reg_mask(reg_mask), .wb(wb), .sp_in(sp_in), .lr_in(lr_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wr(rf_wr), .pc_wr(pc_wr), .pc_data(pc_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_wr(dmem_wr), .sp_wr(sp_wr), .sp_out(sp_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] rf  [0:7];
  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (dmem_wr) mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr];
  end

  typedef struct {
    int          kind;   // 0 dmem write, 1 rf write, 2 pc write, 3 done
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    bit          chkd;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0, n_pass = 0;
  int  tcyc = 0, s_cyc = 0;
  bit  mon_en = 0, done_seen = 0, is_push = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic take(input int kind, input int cyc, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      chk("extra_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_cycle", 32'(cyc), 32'(e.cyc));
      chk("ev_addr", a, e.a);
      if (e.chkd) chk("ev_data", d, e.d);
    end
  endtask

  always @(negedge clk) begin
    int cyc;
    if (mon_en) begin
      cyc = tcyc - s_cyc;
      if (is_push) chk("push_excl", 32'(dmem_wr & rf_wr), 32'h0);
      if (dmem_wr) take(0, cyc, {16'h0, dmem_addr}, dmem_wdata);
      if (rf_wr)   take(1, cyc, {29'h0, rf_waddr}, rf_wdata);
      if (pc_wr)   take(2, cyc, 32'h0, {16'h0, pc_data});
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'h1);
        take(3, cyc, 32'(sp_wr), {16'h0, sp_out});
        done_seen = 1;
      end
    end
  end

  // Independent model of the expected event stream for one operation.
  task automatic gen(input bit pop, input logic [8:0] m, input bit w,
                     input logic [15:0] sp, input logic [15:0] lr);
    int k = 0, j = 0;
    logic [15:0] base, addr;
    ev_t e;
    for (int i = 0; i < 9; i++) if (m[i]) k++;
    base = pop ? sp : sp - 16'(k);
    for (int i = 0; i < 9; i++) begin
      if (m[i]) begin
        addr = base + 16'(j);
        if (!pop)       e = '{0, 1 + j, {16'h0, addr}, (i < 8) ? rf[i] : {16'h0, lr}, 1'b1};
        else if (i < 8) e = '{1, 2 + j, 32'(i), mem[addr], 1'b1};
        else            e = '{2, 2 + j, 32'h0, {16'h0, mem[addr][15:0]}, 1'b1};
        sb.push_back(e);
        j++;
      end
    end
    e = '{3, (k == 0) ? 1 : (pop ? k + 2 : k + 1), 32'(w && k != 0),
          {16'h0, pop ? sp + 16'(k) : sp - 16'(k)}, k != 0};
    sb.push_back(e);
  endtask

  task automatic drive(input bit pop, input logic [8:0] m, input bit w,
                       input logic [15:0] sp, input logic [15:0] lr);
    s_cyc = tcyc;
    done_seen = 0;
    is_push = !pop;
    start = 1; op_pop = pop; reg_mask = m; wb = w; sp_in = sp; lr_in = lr;
  endtask

  task automatic run_op(input bit pop, input logic [8:0] m, input bit w,
                        input logic [15:0] sp, input logic [15:0] lr);
    @(negedge clk);
    gen(pop, m, w, sp, lr);
    drive(pop, m, w, sp, lr);
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 40 && !done_seen; t++) @(posedge clk);
    chk("done_seen", 32'(done_seen), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_strobes"}, {28'h0, dmem_wr, rf_wr, pc_wr, sp_wr}, 0);
    chk({tag, "_dmem_addr"}, {16'h0, dmem_addr}, 0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
    chk({tag, "_rf_w"}, rf_wdata | {29'h0, rf_waddr}, 0);
    chk({tag, "_pc_sp"}, {pc_data, sp_out}, 0);
  endtask

  initial begin
    resetn = 0; start = 0; op_pop = 0; wb = 0; reg_mask = '0; sp_in = '0; lr_in = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) rf[i] = 32'h10 + i;
    rf[0] = 32'hA; rf[1] = 32'hB; rf[3] = 32'hD;
    repeat (2) @(negedge clk);
    #1 rst_chk("reset");
    @(negedge clk);
    resetn = 1;
    mon_en = 1;

    run_op(0, 9'h00B, 1, 16'h0100, 16'h0000);
    mem[16'h00FD] = 32'h1; mem[16'h00FE] = 32'h2; mem[16'h00FF] = 32'h40;
    run_op(1, 9'h105, 1, 16'h00FD, 16'h0000);
    run_op(0, 9'h000, 1, 16'h0200, 16'h0000);
    run_op(0, 9'h1FF, 1, 16'h0004, 16'h1234);
    run_op(1, 9'h1FF, 1, 16'hFFFB, 16'h0000);

    // POP interrupted by reset; a stray start mid-operation must not register.
    @(negedge clk);
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 32'h100 + i;
    gen(1, 9'h0FF, 1, 16'h0010, 16'h0000);
    while (sb.size() > 0 && sb[$].cyc > 3) void'(sb.pop_back());
    drive(1, 9'h0FF, 1, 16'h0010, 16'h0000);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; op_pop = 0; reg_mask = 9'h1FF; sp_in = 16'h0300;
    @(negedge clk);
    start = 0;
    #2 resetn = 0;
    #1 rst_chk("abort");
    chk("abort_sb_empty", 32'(sb.size()), 32'h0);
    @(negedge clk);
    resetn = 1;

    run_op(0, 9'h00A, 1, 16'h0020, 16'h0000);
    run_op(0, 9'h110, 0, 16'h0050, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_xfer_engine.md
# stack_xfer_engine

Parametrised multi-register stack transfer sequencer for the DSD processor core. It is the next generation of the push/pop unit that sits beside the EX stage. It executes one PUSH or POP of an arbitrary register list, plus an optional link/PC slot, against data memory at one word per cycle, then optionally writes back the stack pointer. While the engine is busy the stage FSM holds IR/PC; the engine owns the RF write port and the dmem port.

## Interface
- DW, 32, data word width (RF and dmem data)
- AW, 16, data-memory address width
- NREG, 8, number of general registers; mask width is NREG+1
- RIW, 3, register index width; must satisfy 2^RIW >= NREG
- STEP, 1, address increment per word

- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- op_pop  in  1  0 = PUSH (store), 1 = POP (load); sampled with start
- reg_mask  in  NREG+1  bits [NREG-1:0] = registers; bit NREG = link slot
- wb  in  1  write back SP at end of operation
- sp_in  in  AW  current stack pointer
- lr_in  in  AW  link value stored by PUSH slot NREG, zero-extended to DW
- rf_raddr  out  RIW  RF read index (combinational RF read)
- rf_rdata  in  DW  RF read data
- rf_waddr  out  RIW  RF write index
- rf_wdata  out  DW  RF write data
- rf_wr  out  1  RF write strobe
- pc_wr  out  1  POP of link slot: load PC
- pc_data  out  AW  = low AW bits of the popped word
- dmem_addr  out  AW  data-memory address
- dmem_wdata  out  DW  data-memory write data
- dmem_wr  out  1  data-memory write strobe
- sp_wr  out  1  SP write-back strobe
- sp_out  out  AW  new SP value
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, PUSH, POP, POP_TAIL, FIN.
- start in IDLE latches op_pop, reg_mask, wb, sp_in and lr_in. k = popcount(reg_mask).
- k = 0: go to FIN. No memory access, no sp_wr; done asserts in the next cycle.
- Transfer order is ascending bit index. The lowest set bit goes to the lowest address.
- PUSH (full-descending): base = sp_in - k*STEP. The j-th transfer (j = 0..k-1) writes dmem_addr = base + j*STEP.
  - For a register slot: rf_raddr = index and dmem_wdata = rf_rdata.
  - For slot NREG: dmem_wdata = {0, lr_in}.
  - After the last transfer: FIN, with sp_out = base.
- POP: the j-th transfer issues dmem_addr = sp_in + j*STEP with dmem_wr = 0.
  - Memory returns data one cycle later. In the following cycle: rf_wr with rf_waddr = that slot's index and rf_wdata = dmem_data, or pc_wr for slot NREG.
  - After the last issue: POP_TAIL (final data write), then FIN with sp_out = sp_in + k*STEP.
- FIN: done = 1; sp_wr = wb and k != 0. Then return to IDLE.
- start while busy is ignored and has no effect on the latched operation.
- The remaining-mask register clears its lowest set bit each transfer. A pending-slot register of width RIW+1 tracks the POP data return.
- Address arithmetic is modulo 2^AW. Wrap-around below 0 or above 2^AW-1 is legal and silent.
- dmem_wr and rf_wr are never asserted in the same cycle by a PUSH. POP may assert rf_wr (data return) in the same cycle as a new address issue.

## Timing
- Cycle 0 is the start edge.
- PUSH: dmem_wr high in cycles 1..k; done/sp_wr in cycle k+1.
- POP: issues in cycles 1..k; rf_wr/pc_wr in cycles 2..k+1; done/sp_wr in cycle k+2.
- Earliest next start is the done cycle + 1; start is accepted again in IDLE.
- Reset values: all strobes (rf_wr, pc_wr, dmem_wr, sp_wr, done, busy) = 0; all address and data outputs = 0; state IDLE; latched registers cleared.
- Reset asserted mid-operation aborts immediately. No partial write-back, no done pulse.
- Outputs decode only from state registers. The exceptions are dmem_wdata (rf_rdata passthrough) and rf_wdata/pc_data (dmem data passthrough).

## Test plan
- PUSH, mask 0x00B (r0, r1, r3), sp_in 0x0100, wb = 1, r0/r1/r3 = 0xA/0xB/0xD:
  - dmem writes 0x00FD←0xA, 0x00FE←0xB, 0x00FF←0xD in cycles 1-3.
  - Cycle 4: done, sp_wr, sp_out = 0x00FD.
- POP, mask 0x105 (r0, r2, link), sp_in 0x00FD, memory = 1, 2, 0x0040:
  - r0←1 in cycle 2, r2←2 in cycle 3.
  - Cycle 4: pc_wr with pc_data 0x0040.
  - Cycle 5: done, sp_out = 0x0100.
- Mask 0, wb = 1: done in cycle 1, no dmem_wr, rf_wr or sp_wr.
- PUSH, full mask 0x1FF, sp_in 0x0004:
  - 9 writes from 0xFFFB through 0x0003 (address wrap).
  - done in cycle 10, sp_out 0xFFFB.
- POP in progress: start pulsed in cycle 2 is ignored. Assert resetn low in cycle 3:
  - all outputs 0 immediately.
  - After release, a fresh PUSH runs to completion normally.
- PUSH with wb = 0: writes as normal, done asserted, sp_wr stays 0.
